decode_cycle: RTL and testbench

//  Decode stage of the 5-stage pipeline. It sits directly downstream of fetch_cycle and consumes InstrD, PCD and PCPlus4D.
//  It splits the 34-bit instruction, generates control, reads the register file and sign-extends the immediate.
//  It registers everything into the D/E pipeline register for execute.
//  The writeback stage writes the register file through the W-side port.

---
 rtl/pipeline_pkg.sv | 58 +++++
 rtl/register_file.sv | 54 +++++
 rtl/decode_cycle.sv | 165 ++++++++++++++++
 tb/tb_decode_cycle.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared decode-stage types: opcodes, ALU/result selects, control bundle, field positions.
// No logic; imported by decode_cycle and register_file.
// Optional feature macro DECODE_ILLEGAL_EN is consumed by decode_cycle.
package pipeline_pkg;

   // Instruction field positions within the 34-bit instruction word
   localparam int OP_MSB  = 33;
   localparam int OP_LSB  = 30;
   localparam int RD_MSB  = 29;
   localparam int RD_LSB  = 26;
   localparam int RS1_MSB = 25;
   localparam int RS1_LSB = 22;
   localparam int RS2_MSB = 21;
   localparam int RS2_LSB = 18;
   localparam int IMM_MSB = 17;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = 18;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_ADDI = 4'd5,
      OP_LD   = 4'd6,
      OP_ST   = 4'd7,
      OP_BEQ  = 4'd8,
      OP_JMP  = 4'd9
   } op_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef struct packed {
      logic reg_write;
      logic mem_write;
      logic alu_src;
      logic branch;
      logic jump;
   } ctrl_s;

   // Opcodes above JMP have no defined meaning
   function automatic logic is_illegal(input logic [3:0] op);
      return (op > OP_JMP);
   endfunction

endpackage

// File: rtl/register_file.sv
// 2R1W register file, r0 hard-wired to zero, same-cycle write-through bypass on both reads.
// Latency: reads combinational, write lands on the rising edge.
// No backpressure; writes accepted every cycle regardless of pipeline stall/flush.
module register_file
   import pipeline_pkg::*;
#(
   parameter int NREG   = 16,
   parameter int DATA_W = 32,
   parameter int AW     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     ra1,
   input  logic [AW-1:0]     ra2,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   // Next register contents: a write to r0 is dropped so it always reads zero
   always_comb begin
      regs_d = regs_q;
      if (we && (wa != '0)) begin
         regs_d[wa] = wd;
      end
   end

   // Storage with asynchronous clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read ports: r0 first, then the in-flight writeback value, then storage
   always_comb begin
      rd1 = regs_q[ra1];
      rd2 = regs_q[ra2];
      if (ra1 == '0)                rd1 = '0;
      else if (we && (wa == ra1))   rd1 = wd;
      if (ra2 == '0)                rd2 = '0;
      else if (we && (wa == ra2))   rd2 = wd;
   end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: field split, control decode, register read, imm18 sign-extend, D/E pipeline register.
// Latency 1 cycle InstrD -> *E. StallE holds D/E, FlushE zeroes it (flush wins); regfile writes continue.
// Optional DECODE_ILLEGAL_EN: flags opcodes 10..15 on IllegalE; otherwise IllegalE is tied low.
module decode_cycle
   import pipeline_pkg::*;
#(
   parameter int INSTR_W = 34,
   parameter int PC_W    = 9,
   parameter int DATA_W  = 32,
   parameter int NREG    = 16,
   parameter int RAW     = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] InstrD,
   input  logic [PC_W-1:0]    PCD,
   input  logic [PC_W-1:0]    PCPlus4D,
   input  logic               RegWriteW,
   input  logic [RAW-1:0]     RdW,
   input  logic [DATA_W-1:0]  ResultW,
   input  logic               StallE,
   input  logic               FlushE,
   output logic               RegWriteE,
   output logic               MemWriteE,
   output logic               ALUSrcE,
   output logic               BranchE,
   output logic               JumpE,
   output logic [1:0]         ResultSrcE,
   output logic [2:0]         ALUControlE,
   output logic [DATA_W-1:0]  RD1E,
   output logic [DATA_W-1:0]  RD2E,
   output logic [DATA_W-1:0]  ImmExtE,
   output logic [RAW-1:0]     Rs1E,
   output logic [RAW-1:0]     Rs2E,
   output logic [RAW-1:0]     RdE,
   output logic [PC_W-1:0]    PCE,
   output logic [PC_W-1:0]    PCPlus4E,
   output logic               IllegalE
);

   typedef struct packed {
      ctrl_s             ctrl;
      result_src_t       result_src;
      alu_ctrl_t         alu_ctrl;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm_ext;
      logic [RAW-1:0]    rs1;
      logic [RAW-1:0]    rs2;
      logic [RAW-1:0]    rd;
      logic [PC_W-1:0]   pc;
      logic [PC_W-1:0]   pc_plus4;
`ifdef DECODE_ILLEGAL_EN
      logic              illegal;
`endif
   } de_t;

   logic [3:0]        op;
   logic [IMM_W-1:0]  imm;
   logic [RAW-1:0]    rs1;
   logic [RAW-1:0]    rs2;
   logic [RAW-1:0]    rd;
   logic [DATA_W-1:0] rf_rd1;
   logic [DATA_W-1:0] rf_rd2;
   de_t               de_new;
   de_t               de_d;
   de_t               de_q;

   assign op  = InstrD[OP_MSB:OP_LSB];
   assign rd  = InstrD[RD_MSB:RD_LSB];
   assign rs1 = InstrD[RS1_MSB:RS1_LSB];
   assign rs2 = InstrD[RS2_MSB:RS2_LSB];
   assign imm = InstrD[IMM_MSB:IMM_LSB];

   register_file #(.NREG(NREG), .DATA_W(DATA_W), .AW(RAW)) u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs1),
      .ra2 (rs2),
      .we  (RegWriteW),
      .wa  (RdW),
      .wd  (ResultW),
      .rd1 (rf_rd1),
      .rd2 (rf_rd2)
   );

   // Control decode plus operand/immediate assembly for the incoming instruction
   always_comb begin
      de_new            = '0;
      de_new.alu_ctrl   = ALU_ADD;
      de_new.result_src = RES_ALU;
      case (op)
         OP_ADD:  de_new.ctrl.reg_write = 1'b1;
         OP_SUB:  begin de_new.ctrl.reg_write = 1'b1; de_new.alu_ctrl = ALU_SUB; end
         OP_AND:  begin de_new.ctrl.reg_write = 1'b1; de_new.alu_ctrl = ALU_AND; end
         OP_OR:   begin de_new.ctrl.reg_write = 1'b1; de_new.alu_ctrl = ALU_OR;  end
         OP_ADDI: begin de_new.ctrl.reg_write = 1'b1; de_new.ctrl.alu_src = 1'b1; end
         OP_LD: begin
            de_new.ctrl.reg_write = 1'b1;
            de_new.ctrl.alu_src   = 1'b1;
            de_new.result_src     = RES_MEM;
         end
         OP_ST:   begin de_new.ctrl.mem_write = 1'b1; de_new.ctrl.alu_src = 1'b1; end
         OP_BEQ:  begin de_new.ctrl.branch = 1'b1; de_new.alu_ctrl = ALU_SUB; end
         OP_JMP: begin
            de_new.ctrl.jump      = 1'b1;
            de_new.ctrl.reg_write = 1'b1;
            de_new.result_src     = RES_PC4;
         end
         default: ;  // NOP and undefined opcodes leave every control low
      endcase
`ifdef DECODE_ILLEGAL_EN
      de_new.illegal  = is_illegal(op);
`endif
      de_new.rd1      = rf_rd1;
      de_new.rd2      = rf_rd2;
      de_new.imm_ext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      de_new.rs1      = rs1;
      de_new.rs2      = rs2;
      de_new.rd       = rd;
      de_new.pc       = PCD;
      de_new.pc_plus4 = PCPlus4D;
   end

   // D/E next state: flush beats stall, stall beats load
   always_comb begin
      de_d = de_q;
      if (FlushE) begin
         de_d = '0;
      end else if (!StallE) begin
         de_d = de_new;
      end
   end

   // D/E pipeline register with asynchronous clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         de_q <= '0;
      end else begin
         de_q <= de_d;
      end
   end

   assign RegWriteE   = de_q.ctrl.reg_write;
   assign MemWriteE   = de_q.ctrl.mem_write;
   assign ALUSrcE     = de_q.ctrl.alu_src;
   assign BranchE     = de_q.ctrl.branch;
   assign JumpE       = de_q.ctrl.jump;
   assign ResultSrcE  = de_q.result_src;
   assign ALUControlE = de_q.alu_ctrl;
   assign RD1E        = de_q.rd1;
   assign RD2E        = de_q.rd2;
   assign ImmExtE     = de_q.imm_ext;
   assign Rs1E        = de_q.rs1;
   assign Rs2E        = de_q.rs2;
   assign RdE         = de_q.rd;
   assign PCE         = de_q.pc;
   assign PCPlus4E    = de_q.pc_plus4;
`ifdef DECODE_ILLEGAL_EN
   assign IllegalE    = de_q.illegal;
`else
   assign IllegalE    = 1'b0;
`endif

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: scoreboard of expected D/E contents per cycle.
// Expected values are built from the instruction semantics, one task per scenario.
// Honours DECODE_ILLEGAL_EN for the expected IllegalE value.
module tb_decode_cycle;

   localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, AND = 4'd3, OR = 4'd4,
                          ADDI = 4'd5, LD = 4'd6, ST = 4'd7, BEQ = 4'd8, JMP = 4'd9;
`ifdef DECODE_ILLEGAL_EN
   localparam logic ILL = 1'b1;
`else
   localparam logic ILL = 1'b0;
`endif

   typedef struct packed {
      logic        rw, mw, as, br, jp;
      logic [1:0]  rs;
      logic [2:0]  alu;
      logic [31:0] rd1, rd2, imm;
      logic [3:0]  rs1, rs2, rd;
      logic [8:0]  pc, pc4;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [33:0] InstrD = '0;
   logic [8:0]  PCD = '0, PCPlus4D = '0;
   logic        RegWriteW = 1'b0;
   logic [3:0]  RdW = '0;
   logic [31:0] ResultW = '0;
   logic        StallE = 1'b0, FlushE = 1'b0;
   logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, IllegalE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, ImmExtE;
   logic [3:0]  Rs1E, Rs2E, RdE;
   logic [8:0]  PCE, PCPlus4E;

   exp_t obs;
   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   decode_cycle dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .StallE(StallE), .FlushE(FlushE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
      .JumpE(JumpE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E),
      .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE),
      .PCPlus4E(PCPlus4E), .IllegalE(IllegalE)
   );

   assign obs = {RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE,
                 RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E, IllegalE};

   function automatic logic [33:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [17:0] imm);
      return {op, rd, rs1, rs2, imm};
   endfunction

   function automatic exp_t mk(input logic rw, input logic mw, input logic as, input logic br,
                               input logic jp, input logic [1:0] rs, input logic [2:0] alu,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic [3:0] rs1,
                               input logic [3:0] rs2, input logic [3:0] rd,
                               input logic [8:0] pc, input logic ill);
      exp_t e;
      e = '{rw, mw, as, br, jp, rs, alu, rd1, rd2, imm, rs1, rs2, rd, pc, pc + 9'd4, ill};
      return e;
   endfunction

   // Drive one decode cycle at the falling edge and record what D/E must hold afterwards
   task automatic apply(input logic [33:0] instr, input logic [8:0] pc, input logic wen,
                        input logic [3:0] wrd, input logic [31:0] wdat, input logic stall,
                        input logic flush, input exp_t e);
      @(negedge clk);
      InstrD = instr; PCD = pc; PCPlus4D = pc + 9'd4;
      RegWriteW = wen; RdW = wrd; ResultW = wdat;
      StallE = stall; FlushE = flush;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      fork
         begin
            repeat (5) apply(ins(ADD, 2, 3, 4, 18'h00001), 9'h010, 1'b0, 4'd0, 0, 1'b0, 1'b0, '0);
            apply(ins(ADD, 2, 3, 4, 18'h0), 9'h010, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b000, 0, 0, 0, 3, 4, 2, 9'h010, 0));
            rst = 1'b1;
         end
         begin
            repeat (6) begin
               @(posedge clk); #1;
               tests++;
               if (sb.size() == 0) begin
                  fails++; $display("FAIL reset: no expected entry queued");
               end else begin
                  e = sb.pop_front();
                  if (obs !== e) begin
                     fails++; $display("FAIL reset: got %h, expected %h", obs, e);
                  end
               end
            end
         end
      join
   endtask

   task automatic test_alu_ops();
      exp_t e;
      fork
         begin
            apply(ins(NOP, 0, 0, 0, 0), 9'h020, 1'b1, 4'd3, 32'h12345678, 1'b0, 1'b0,
                  mk(0,0,0,0,0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 9'h020, 0));
            apply(ins(ADD, 1, 3, 0, 0), 9'h024, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b000, 32'h12345678, 0, 0, 3, 0, 1, 9'h024, 0));
            apply(ins(SUB, 2, 3, 3, 0), 9'h028, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b001, 32'h12345678, 32'h12345678, 0, 3, 3, 2, 9'h028, 0));
            apply(ins(AND, 6, 0, 3, 0), 9'h02C, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b010, 0, 32'h12345678, 0, 0, 3, 6, 9'h02C, 0));
            apply(ins(OR, 7, 3, 0, 0), 9'h030, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b011, 32'h12345678, 0, 0, 3, 0, 7, 9'h030, 0));
            apply(ins(ST, 0, 3, 3, 18'h4), 9'h034, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(0,1,1,0,0, 2'b00, 3'b000, 32'h12345678, 32'h12345678, 4, 3, 3, 0, 9'h034, 0));
            apply(ins(BEQ, 0, 3, 0, 18'h3FFF8), 9'h038, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(0,0,0,1,0, 2'b00, 3'b001, 32'h12345678, 0, 32'hFFFFFFF8, 3, 0, 0, 9'h038, 0));
            apply(ins(JMP, 15, 0, 0, 18'h10), 9'h03C, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,0,0,1, 2'b10, 3'b000, 0, 0, 32'h10, 0, 0, 15, 9'h03C, 0));
            apply(ins(NOP, 5, 3, 3, 18'h7), 9'h040, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(0,0,0,0,0, 2'b00, 3'b000, 32'h12345678, 32'h12345678, 7, 3, 3, 5, 9'h040, 0));
         end
         begin
            repeat (9) begin
               @(posedge clk); #1;
               tests++;
               if (sb.size() == 0) begin
                  fails++; $display("FAIL alu_ops: no expected entry queued");
               end else begin
                  e = sb.pop_front();
                  if (obs !== e) begin
                     fails++; $display("FAIL alu_ops: got %h, expected %h", obs, e);
                  end
               end
            end
         end
      join
   endtask

   task automatic test_imm();
      exp_t e;
      fork
         begin
            apply(ins(ADDI, 7, 0, 0, 18'h3FFFF), 9'h060, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,1,0,0, 2'b00, 3'b000, 0, 0, 32'hFFFFFFFF, 0, 0, 7, 9'h060, 0));
            apply(ins(ADDI, 7, 0, 0, 18'h1FFFF), 9'h064, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,1,0,0, 2'b00, 3'b000, 0, 0, 32'h0001FFFF, 0, 0, 7, 9'h064, 0));
            apply(ins(ADDI, 4, 3, 0, 18'h20000), 9'h068, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,1,0,0, 2'b00, 3'b000, 32'h12345678, 0, 32'hFFFE0000, 3, 0, 4, 9'h068, 0));
         end
         begin
            repeat (3) begin
               @(posedge clk); #1;
               tests++;
               if (sb.size() == 0) begin
                  fails++; $display("FAIL imm: no expected entry queued");
               end else begin
                  e = sb.pop_front();
                  if (obs !== e) begin
                     fails++; $display("FAIL imm: got %h, expected %h", obs, e);
                  end
               end
            end
         end
      join
   endtask

   task automatic test_bypass();
      exp_t e;
      fork
         begin
            apply(ins(ADD, 1, 5, 5, 0), 9'h080, 1'b1, 4'd5, 32'hA5, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b000, 32'hA5, 32'hA5, 0, 5, 5, 1, 9'h080, 0));
            apply(ins(ADD, 1, 0, 5, 0), 9'h084, 1'b1, 4'd0, 32'hDEAD, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b000, 0, 32'hA5, 0, 0, 5, 1, 9'h084, 0));
            apply(ins(ADD, 1, 0, 5, 0), 9'h088, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b000, 0, 32'hA5, 0, 0, 5, 1, 9'h088, 0));
            apply(ins(ADD, 1, 5, 0, 0), 9'h08C, 1'b0, 4'd5, 32'hFF, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b000, 32'hA5, 0, 0, 5, 0, 1, 9'h08C, 0));
            apply(ins(ADD, 1, 3, 5, 0), 9'h090, 1'b1, 4'd5, 32'h5A, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b000, 32'h12345678, 32'h5A, 0, 3, 5, 1, 9'h090, 0));
         end
         begin
            repeat (5) begin
               @(posedge clk); #1;
               tests++;
               if (sb.size() == 0) begin
                  fails++; $display("FAIL bypass: no expected entry queued");
               end else begin
                  e = sb.pop_front();
                  if (obs !== e) begin
                     fails++; $display("FAIL bypass: got %h, expected %h", obs, e);
                  end
               end
            end
         end
      join
   endtask

   task automatic test_stall_flush();
      exp_t e, e_ld;
      e_ld = mk(1,0,1,0,0, 2'b01, 3'b000, 32'h12345678, 0, 32'h10, 3, 0, 8, 9'h0A0, 0);
      fork
         begin
            apply(ins(LD, 8, 3, 0, 18'h10), 9'h0A0, 1'b0, 4'd0, 0, 1'b0, 1'b0, e_ld);
            apply(ins(OR, 9, 5, 5, 0), 9'h0A4, 1'b1, 4'd9, 32'h99, 1'b1, 1'b0, e_ld);
            apply(ins(JMP, 1, 1, 1, 1), 9'h0A8, 1'b0, 4'd0, 0, 1'b1, 1'b0, e_ld);
            apply(ins(ADD, 1, 9, 0, 0), 9'h0AC, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b000, 32'h99, 0, 0, 9, 0, 1, 9'h0AC, 0));
            apply(ins(JMP, 4, 3, 3, 18'h5), 9'h0B0, 1'b1, 4'd10, 32'hAA, 1'b1, 1'b1, '0);
            apply(ins(ADD, 1, 10, 0, 0), 9'h0B4, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b000, 32'hAA, 0, 0, 10, 0, 1, 9'h0B4, 0));
            apply(ins(ADD, 1, 3, 3, 0), 9'h0B8, 1'b0, 4'd0, 0, 1'b0, 1'b1, '0);
            apply(ins(OR, 2, 10, 9, 0), 9'h0BC, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,0,0,0, 2'b00, 3'b011, 32'hAA, 32'h99, 0, 10, 9, 2, 9'h0BC, 0));
         end
         begin
            repeat (8) begin
               @(posedge clk); #1;
               tests++;
               if (sb.size() == 0) begin
                  fails++; $display("FAIL stall_flush: no expected entry queued");
               end else begin
                  e = sb.pop_front();
                  if (obs !== e) begin
                     fails++; $display("FAIL stall_flush: got %h, expected %h", obs, e);
                  end
               end
            end
         end
      join
   endtask

   task automatic test_illegal();
      exp_t e;
      fork
         begin
            apply(ins(4'd12, 3, 3, 0, 18'h5), 9'h0C0, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(0,0,0,0,0, 2'b00, 3'b000, 32'h12345678, 0, 5, 3, 0, 3, 9'h0C0, ILL));
            apply(ins(4'd10, 3, 3, 0, 18'h5), 9'h0C4, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(0,0,0,0,0, 2'b00, 3'b000, 32'h12345678, 0, 5, 3, 0, 3, 9'h0C4, ILL));
            apply(ins(4'd15, 3, 3, 0, 18'h5), 9'h0C8, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(0,0,0,0,0, 2'b00, 3'b000, 32'h12345678, 0, 5, 3, 0, 3, 9'h0C8, ILL));
            apply(ins(JMP, 3, 3, 0, 18'h5), 9'h0CC, 1'b0, 4'd0, 0, 1'b0, 1'b0,
                  mk(1,0,0,0,1, 2'b10, 3'b000, 32'h12345678, 0, 5, 3, 0, 3, 9'h0CC, 0));
         end
         begin
            repeat (4) begin
               @(posedge clk); #1;
               tests++;
               if (sb.size() == 0) begin
                  fails++; $display("FAIL illegal: no expected entry queued");
               end else begin
                  e = sb.pop_front();
                  if (obs !== e) begin
                     fails++; $display("FAIL illegal: got %h, expected %h", obs, e);
                  end
               end
            end
         end
      join
   endtask

   // Reset asserted between clock edges must clear D/E immediately and wipe the register file
   task automatic test_midop_reset();
      exp_t e;
      apply(ins(ADD, 1, 3, 0, 0), 9'h0D0, 1'b0, 4'd0, 0, 1'b0, 1'b0,
            mk(1,0,0,0,0, 2'b00, 3'b000, 32'h12345678, 0, 0, 3, 0, 1, 9'h0D0, 0));
      @(posedge clk); #1;
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
         fails++; $display("FAIL midop_load: got %h, expected %h", obs, e);
      end
      #2 rst = 1'b0;
      sb.push_back('0);
      #1;
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
         fails++; $display("FAIL midop_async_clear: got %h, expected %h", obs, e);
      end
      apply(ins(ADD, 1, 3, 0, 0), 9'h0D4, 1'b0, 4'd0, 0, 1'b0, 1'b0, '0);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
         fails++; $display("FAIL midop_held: got %h, expected %h", obs, e);
      end
      apply(ins(ADD, 1, 3, 3, 0), 9'h0D8, 1'b0, 4'd0, 0, 1'b0, 1'b0,
            mk(1,0,0,0,0, 2'b00, 3'b000, 0, 0, 0, 3, 3, 1, 9'h0D8, 0));
      rst = 1'b1;
      @(posedge clk); #1;
      e = sb.pop_front();
      tests++;
      if (obs !== e) begin
         fails++; $display("FAIL midop_rf_cleared: got %h, expected %h", obs, e);
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_alu_ops();
      test_imm();
      test_bypass();
      test_stall_flush();
      test_illegal();
      test_midop_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time budget");
      $fatal(1, "timeout");
   end

endmodule
